// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for a 5-stage RISC-V pipeline. It arbitrates,
// in fixed priority order (reset > memory wait > taken redirect > load-use),
// between the following hazard sources:
//   - data-memory wait states,
//   - taken branch/jump redirects, which flush the wrong-path decode slot,
//   - load-use hazards, which insert one bubble.
// It also keeps a saturating stall-cycle counter and a sticky memory-timeout
// flag.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid, id_rs1/rs2,     decode-stage instruction and its source operands
//   id_uses_rs1/rs2
//   ex_valid, ex_rd,          execute-stage instruction, destination register,
//   ex_is_load,               load flag and resolved branch/jump outcome
//   ex_branch_taken
//   mem_busy                  data memory not ready this cycle
//   fetch_ready/fetch_stall/  fetch controls (load PC/IR, drop valid,
//   redirect_valid            take ALU target)
//   id_hold/id_bubble/        decode controls (keep, insert NOP, kill)
//   flush_id
//   state                     RUN=0, FLUSH=1, MEM_WAIT=2
//   stall_cycles              saturating count of cycles with fetch_ready=0
//   err_timeout               sticky: memory stayed busy beyond MEM_WAIT_MAX
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_DEPTH  = 2,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        fetch_ready,
  output logic        fetch_stall,
  output logic        redirect_valid,
  output logic        id_hold,
  output logic        id_bubble,
  output logic        flush_id,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH - 32'd1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_q, stall_d;
  logic        err_q, err_d;

  logic load_use_s;
  logic taken_s;
  logic fetch_ready_s, fetch_stall_s, redirect_valid_s;
  logic id_hold_s, id_bubble_s, flush_id_s;

  // A load in execute whose (non-x0) destination feeds a decode operand.
  assign load_use_s = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Redirects are only honoured in RUN; in FLUSH the execute slot is wrong-path.
  assign taken_s = ex_valid & ex_branch_taken & (state_q == ST_RUN);

  // Next-state and control-output decode.
  always_comb begin
    state_d          = state_q;
    ret_d            = ret_q;
    flush_cnt_d      = flush_cnt_q;
    wait_cnt_d       = wait_cnt_q;
    err_d            = err_q;
    fetch_ready_s    = 1'b0;
    fetch_stall_s    = 1'b0;
    redirect_valid_s = 1'b0;
    id_hold_s        = 1'b0;
    id_bubble_s      = 1'b0;
    flush_id_s       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          fetch_stall_s = 1'b1;
          id_hold_s     = 1'b1;
          state_d       = ST_MEM_WAIT;
          ret_d         = ST_RUN;
          wait_cnt_d    = 8'd1;
        end else if (taken_s) begin
          redirect_valid_s = 1'b1;
          fetch_ready_s    = 1'b1;
          fetch_stall_s    = 1'b1;
          flush_id_s       = 1'b1;
          id_bubble_s      = 1'b1;
          if (FLUSH_DEPTH > 32'd1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end else begin
            state_d = ST_RUN;
          end
        end else if (load_use_s) begin
          fetch_stall_s = 1'b1;
          id_hold_s     = 1'b1;
          id_bubble_s   = 1'b1;
        end else begin
          fetch_ready_s = 1'b1;
        end
      end

      ST_FLUSH: begin
        flush_id_s    = 1'b1;
        id_bubble_s   = 1'b1;
        fetch_ready_s = 1'b1;
        fetch_stall_s = 1'b1;
        if (mem_busy) begin
          // Park the flush with its remaining count frozen.
          state_d    = ST_MEM_WAIT;
          ret_d      = ST_FLUSH;
          wait_cnt_d = 8'd1;
        end else if (flush_cnt_q <= 3'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = 3'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end

      ST_MEM_WAIT: begin
        fetch_stall_s = 1'b1;
        id_hold_s     = 1'b1;
        if (mem_busy) begin
          if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
          // wait_cnt_q already counts MEM_WAIT_MAX busy cycles: one more is too many.
          if (wait_cnt_q >= WAIT_LIMIT) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d    = ret_q;
          wait_cnt_d = 8'd0;
        end
      end

      default: begin
        state_d     = ST_RUN;
        ret_d       = ST_RUN;
        flush_cnt_d = 3'd0;
        wait_cnt_d  = 8'd0;
      end
    endcase

    if (!fetch_ready_s && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      flush_cnt_q <= 3'd0;
      wait_cnt_q  <= 8'd0;
      stall_q     <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

  // While reset is held the pipeline is frozen with fetch invalidated.
  assign fetch_ready    = rst ? 1'b0 : fetch_ready_s;
  assign fetch_stall    = rst ? 1'b1 : fetch_stall_s;
  assign redirect_valid = rst ? 1'b0 : redirect_valid_s;
  assign id_hold        = rst ? 1'b0 : id_hold_s;
  assign id_bubble      = rst ? 1'b0 : id_bubble_s;
  assign flush_id       = rst ? 1'b0 : flush_id_s;
  assign state          = state_q;
  assign stall_cycles   = stall_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int FD  = 2;
  localparam int MWM = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_branch_taken;
  logic        mem_busy;
  logic        fetch_ready;
  logic        fetch_stall;
  logic        redirect_valid;
  logic        id_hold;
  logic        id_bubble;
  logic        flush_id;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic        err_timeout;

  pipe_hazard_ctrl #(.FLUSH_DEPTH(FD), .MEM_WAIT_MAX(MWM)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .fetch_ready(fetch_ready), .fetch_stall(fetch_stall),
    .redirect_valid(redirect_valid), .id_hold(id_hold),
    .id_bubble(id_bubble), .flush_id(flush_id), .state(state),
    .stall_cycles(stall_cycles), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode 0=RUN 1=FLUSH 2=MEM_WAIT.
  int m_mode, m_ret, m_flush_left, m_busy_run, m_stall;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; ex_rd = 5'd0; ex_is_load = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_ret = 0; m_flush_left = 0; m_busy_run = 0; m_stall = 0; m_err = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic run_cycle();
    logic [5:0] exp_ctrl;
    bit lu, tk;
    @(negedge clk);
    lu = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    tk = ex_valid && ex_branch_taken;
    // {fetch_ready, fetch_stall, redirect_valid, id_hold, id_bubble, flush_id}
    if (rst)              exp_ctrl = 6'b010000;
    else if (m_mode == 1) exp_ctrl = 6'b110011;
    else if (m_mode == 2) exp_ctrl = 6'b010100;
    else if (mem_busy)    exp_ctrl = 6'b010100;
    else if (tk)          exp_ctrl = 6'b111011;
    else if (lu)          exp_ctrl = 6'b010110;
    else                  exp_ctrl = 6'b100000;
    check("ctrl", {26'd0, fetch_ready, fetch_stall, redirect_valid, id_hold, id_bubble, flush_id},
          {26'd0, exp_ctrl});
    check("state", {30'd0, state}, m_mode);
    check("stall_cycles", {16'd0, stall_cycles}, m_stall);
    check("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (!exp_ctrl[5] && m_stall < 65535) m_stall++;
      if (m_mode == 0) begin
        if (mem_busy) begin
          m_ret = 0; m_busy_run = 1; m_mode = 2;
        end else if (tk && FD > 1) begin
          m_mode = 1; m_flush_left = FD - 1;
        end
      end else if (m_mode == 1) begin
        if (mem_busy) begin
          m_ret = 1; m_busy_run = 1; m_mode = 2;
        end else begin
          m_flush_left--;
          if (m_flush_left == 0) m_mode = 0;
        end
      end else begin
        if (mem_busy) begin
          // More than MWM consecutive busy cycles is a timeout.
          if (m_busy_run + 1 > MWM) m_err = 1'b1;
          m_busy_run++;
        end else begin
          m_mode = m_ret; m_busy_run = 0;
        end
      end
    end
    #1;
  endtask

  int stall_before;
  int burst_left;

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    run_cycle();                        // reset-forced outputs
    rst = 1'b0;

    // Idle after reset.
    repeat (3) run_cycle();
    check("idle_state", {30'd0, state}, 32'd0);
    check("idle_stall", {16'd0, stall_cycles}, 32'd0);

    // Load-use on rs2: exactly one bubble; then x0 destination never stalls.
    id_valid = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
    run_cycle();
    ex_valid = 1'b0;
    run_cycle();
    check("load_use_stall", {16'd0, stall_cycles}, 32'd1);
    ex_valid = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    run_cycle();
    check("x0_no_stall", {16'd0, stall_cycles}, 32'd1);
    clear_inputs();

    // Taken branch, held high through the flush cycle.
    ex_valid = 1'b1; ex_branch_taken = 1'b1;
    run_cycle();
    run_cycle();
    clear_inputs();
    run_cycle();

    // Branch and load-use together: redirect wins.
    id_valid = 1'b1; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    ex_valid = 1'b1; ex_rd = 5'd7; ex_is_load = 1'b1; ex_branch_taken = 1'b1;
    run_cycle();
    clear_inputs();
    repeat (2) run_cycle();

    // Memory wait entered from the first flush cycle.
    stall_before = stall_cycles;
    ex_valid = 1'b1; ex_branch_taken = 1'b1;
    run_cycle();
    clear_inputs();
    mem_busy = 1'b1;
    repeat (4) run_cycle();
    mem_busy = 1'b0;
    repeat (4) run_cycle();
    check("flush_wait_stall", {16'd0, stall_cycles}, stall_before + 4);

    // Memory timeout, sticky until reset.
    mem_busy = 1'b1;
    repeat (20) run_cycle();
    mem_busy = 1'b0;
    repeat (2) run_cycle();
    check("timeout_sticky", {31'd0, err_timeout}, 32'd1);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    run_cycle();
    check("timeout_cleared", {31'd0, err_timeout}, 32'd0);

    // Randomized traffic with small register indices and bursty memory waits.
    burst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      id_valid        = $urandom_range(0, 3) != 0;
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_valid        = $urandom_range(0, 3) != 0;
      ex_rd           = 5'($urandom_range(0, 3));
      ex_is_load      = 1'($urandom_range(0, 1));
      ex_branch_taken = $urandom_range(0, 5) == 0;
      if (burst_left > 0) begin
        mem_busy = 1'b1;
        burst_left--;
      end else if ($urandom_range(0, 15) == 0) begin
        mem_busy = 1'b1;
        burst_left = $urandom_range(0, 19);
      end else begin
        mem_busy = 1'b0;
      end
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Drives the fetch stage's ready, stall and redirect-qualify inputs, and the decode stage's hold, bubble and flush controls.
- Resolves load-use hazards, taken-branch/jump redirects and data-memory wait states with a fixed priority.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
FLUSH_DEPTH, 2, cycles flush_id is asserted per redirect, including the redirect cycle (legal 1..7).
MEM_WAIT_MAX, 15, consecutive mem_busy cycles tolerated before err_timeout sets (legal 1..255).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  decode holds a valid instruction
id_rs1  in  5  decode source register 1
id_rs2  in  5  decode source register 2
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
ex_valid  in  1  execute holds a valid instruction
ex_rd  in  5  execute destination register
ex_is_load  in  1  execute instruction is a load
ex_branch_taken  in  1  ALU comparison / jump result, PC must take ALU target
mem_busy  in  1  data memory not ready this cycle
fetch_ready  out  1  fetch may load a new PC/IR (fetch r_in)
fetch_stall  out  1  fetch must drop its valid (fetch stall)
redirect_valid  out  1  qualifies the ALU target as next PC (fetch v_in)
id_hold  out  1  decode register keeps its contents
id_bubble  out  1  insert NOP into execute this cycle
flush_id  out  1  kill the instruction in decode
state  out  2  RUN=0, FLUSH=1, MEM_WAIT=2 (3 unused)
stall_cycles  out  16  saturating count of cycles with fetch_ready=0
err_timeout  out  1  sticky: mem_busy exceeded MEM_WAIT_MAX

Behaviour:
- Reset (rst=1 at an edge):
  - state=RUN; flush_cnt=0; wait_cnt=0; ret_state=RUN; stall_cycles=0; err_timeout=0.
  - While rst is high, outputs are forced: fetch_ready=0, fetch_stall=1, all other control outputs 0.
  - Reset mid-FLUSH or mid-MEM_WAIT aborts that state with no residue.
- load_use (combinational) = id_valid & ex_valid & ex_is_load & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- taken (combinational) = ex_valid & ex_branch_taken & (state==RUN).
- Priority within a cycle: rst > mem_busy > taken > load_use.
- RUN:
  - mem_busy=1: all outputs as MEM_WAIT; next MEM_WAIT; ret_state=RUN; wait_cnt=1.
  - taken: redirect_valid=1, fetch_ready=1, fetch_stall=1, flush_id=1, id_bubble=1.
    - If FLUSH_DEPTH>1: next FLUSH, flush_cnt=FLUSH_DEPTH-1.
    - Else: remain in RUN.
    - A simultaneous load_use is ignored.
  - load_use: fetch_ready=0, fetch_stall=1, id_hold=1, id_bubble=1 for that cycle; stay in RUN. The hazard clears once the load leaves execute, giving exactly one bubble per load.
  - Otherwise: fetch_ready=1; all other control outputs 0.
- FLUSH:
  - Outputs: flush_id=1, id_bubble=1, fetch_ready=1, fetch_stall=1, redirect_valid=0. ex_branch_taken is ignored because the instruction is wrong-path.
  - flush_cnt decrements each cycle; next state is RUN when flush_cnt==1 at the edge.
  - mem_busy=1 takes priority: next MEM_WAIT, ret_state=FLUSH, flush_cnt frozen.
- MEM_WAIT:
  - Outputs: fetch_ready=0, fetch_stall=1, id_hold=1; id_bubble, flush_id and redirect_valid are 0.
  - wait_cnt increments, saturating at 255.
  - When wait_cnt reaches MEM_WAIT_MAX with mem_busy still 1, err_timeout sets and stays set until rst. The state machine keeps waiting.
  - mem_busy=0: next ret_state; wait_cnt=0. FLUSH resumes with its frozen flush_cnt.
- stall_cycles increments on every non-reset cycle with fetch_ready=0, saturating at 0xFFFF.
- All outputs except stall_cycles and err_timeout are combinational from the registered state and the current inputs. Latency from an input event to its control output is 0 cycles.

Test Plan:
1. Reset then idle (id_valid=0, mem_busy=0) for 3 cycles -> state=0, fetch_ready=1, fetch_stall=0, stall_cycles=0.
2. Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, held 1 cycle -> exactly 1 cycle of fetch_ready=0, id_hold=1, id_bubble=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
3. Taken branch with FLUSH_DEPTH=2 -> redirect_valid=1 for 1 cycle; flush_id=1 for 2 cycles; state sequence 0,1,0. ex_branch_taken held high during FLUSH -> no second redirect.
4. Branch and load_use in the same cycle -> redirect wins: redirect_valid=1, id_hold=0.
5. mem_busy asserted in the first FLUSH cycle for 4 cycles -> state=2 for 4 cycles, then returns to FLUSH for 1 more flush cycle, then RUN; stall_cycles=4.
6. mem_busy held 20 cycles with MEM_WAIT_MAX=15 -> err_timeout rises after 15 busy cycles and stays 1 after mem_busy drops. Assert rst -> err_timeout=0, state=0.
